// File: rtl/obj_pkg.sv
// obj_pkg
// Shared definitions for the object table and the shape renderer.
// Holds the object-word field positions, shape enums, request op codes,
// the scheduler FSM state type, a few 12-bit colors and a helper that
// packs an object word from its fields.
package obj_pkg;

    localparam int OBJ_W      = 66;
    localparam int ENUM_BITS  = 4;
    localparam int COORD_BITS = 10;
    localparam int COLOR_BITS = 12;

    localparam int ENUM_LSB   = 62;
    localparam int X_LSB      = 52;
    localparam int Y_LSB      = 42;
    localparam int W_LSB      = 32;
    localparam int H_LSB      = 22;
    localparam int R_LSB      = 12;
    localparam int COLOR_LSB  = 0;

    typedef enum logic [ENUM_BITS-1:0] {
        SHAPE_NONE      = 4'd0,
        SHAPE_RECTANGLE = 4'd1,
        SHAPE_CIRCLE    = 4'd2,
        SHAPE_ROUNDRECT = 4'd3
    } shape_t;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_WRITE  = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_DELETE = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sched_state_t;

    localparam logic [COLOR_BITS-1:0] COLOR_BLACK = 12'h000;
    localparam logic [COLOR_BITS-1:0] COLOR_RED   = 12'hF00;
    localparam logic [COLOR_BITS-1:0] COLOR_GREEN = 12'h0F0;
    localparam logic [COLOR_BITS-1:0] COLOR_BLUE  = 12'h00F;
    localparam logic [COLOR_BITS-1:0] COLOR_WHITE = 12'hFFF;

    // Build an object word in the renderer's field order.
    function automatic logic [OBJ_W-1:0] make_obj(
        input shape_t                  shape,
        input logic [COORD_BITS-1:0]   x,
        input logic [COORD_BITS-1:0]   y,
        input logic [COORD_BITS-1:0]   w,
        input logic [COORD_BITS-1:0]   h,
        input logic [COORD_BITS-1:0]   r,
        input logic [COLOR_BITS-1:0]   color
    );
        return {shape, x, y, w, h, r, color};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-requester round-robin arbiter with at most one grant per cycle.
// Ports:
//   clk25  - pixel clock
//   rst    - asynchronous active-low reset (pointer back to requester 0)
//   enable - when low no grant is issued
//   valid  - request valid, bit n = requester n
//   grant  - one-hot grant, combinational from valid and the pointer
module rr_arbiter2 (
    input  logic       clk25,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic ptr_q;

    // Contention goes to the requester the pointer names; a lone
    // requester wins regardless of the pointer.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    // After any grant the pointer moves to the requester that lost out,
    // i.e. a grant to 0 points at 1 and a grant to 1 points at 0.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (|grant) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/obj_table_scheduler.sv
// obj_table_scheduler
// Owns the renderer's object table. Two requesters write a shadow table;
// the shadow is copied atomically into the live table on frame_start so
// the renderer never sees a half-updated list.
// Ports:
//   clk25, rst      - pixel clock, asynchronous active-low reset
//   frame_start     - one-cycle pulse at start of vertical blanking
//   req_valid/ready - per-requester handshake (bit n = requester n)
//   req_op          - 2 bits per requester: NOP, WRITE, CLEAR, DELETE
//   req_idx/req_obj - target slot and object word per requester
//   obj_arr_packed  - live table, slot i at [(i+1)*OBJ_WIDTH-1 : i*OBJ_WIDTH]
//   obj_arr_len     - index of the first NONE slot at the last commit
//   busy            - high while the shadow is being swept by CLEAR
//   commit          - one-cycle pulse after each live-table update
//   drop_err        - sticky flag for an out-of-range slot index
module obj_table_scheduler
    import obj_pkg::*;
#(
    parameter int OBJ_WIDTH = 66,
    parameter int MAX_LEN   = 16,
    parameter int IDX_BITS  = 4,
    parameter int LEN_BITS  = 6
) (
    input  logic                          clk25,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [3:0]                    req_op,
    input  logic [2*IDX_BITS-1:0]         req_idx,
    input  logic [2*OBJ_WIDTH-1:0]        req_obj,
    output logic [OBJ_WIDTH*MAX_LEN-1:0]  obj_arr_packed,
    output logic [LEN_BITS-1:0]           obj_arr_len,
    output logic                          busy,
    output logic                          commit,
    output logic                          drop_err
);

    sched_state_t           state_q, state_d;
    logic [IDX_BITS-1:0]    clr_cnt_q;
    logic [OBJ_WIDTH-1:0]   shadow_q [MAX_LEN];
    logic [OBJ_WIDTH-1:0]   live_q   [MAX_LEN];
    logic                   dirty_q;
    logic                   commit_q;
    logic                   drop_err_q;
    logic [LEN_BITS-1:0]    len_q;
    logic [LEN_BITS-1:0]    first_none;

    logic                   commit_now;
    logic                   arb_enable;
    logic [1:0]             grant;
    logic                   grant_any;
    logic                   sel;
    op_t                    sel_op;
    logic [IDX_BITS-1:0]    sel_idx;
    logic [OBJ_WIDTH-1:0]   sel_obj;
    logic                   idx_ok;
    logic                   clr_last;
    logic                   slot_op;

    // A commit claims the whole cycle, so requests are held off whenever
    // one is about to happen; nothing is granted during a sweep either.
    assign commit_now = frame_start && (state_q == ST_IDLE) && dirty_q;
    assign arb_enable = (state_q == ST_IDLE) && !commit_now;

    rr_arbiter2 u_arb (
        .clk25  (clk25),
        .rst    (rst),
        .enable (arb_enable),
        .valid  (req_valid),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign grant_any = |grant;

    // Mux the winning requester's fields. The extra bit on the index
    // compare keeps the range check meaningful when MAX_LEN fills the
    // whole index space (then every index is in range).
    assign sel      = grant[1];
    assign sel_op   = op_t'(sel ? req_op[3:2] : req_op[1:0]);
    assign sel_idx  = sel ? req_idx[2*IDX_BITS-1:IDX_BITS] : req_idx[IDX_BITS-1:0];
    assign sel_obj  = sel ? req_obj[2*OBJ_WIDTH-1:OBJ_WIDTH] : req_obj[OBJ_WIDTH-1:0];
    assign idx_ok   = ({1'b0, sel_idx} < (IDX_BITS+1)'(MAX_LEN));
    assign slot_op  = (sel_op == OP_WRITE) || (sel_op == OP_DELETE);
    assign clr_last = (clr_cnt_q == IDX_BITS'(MAX_LEN - 1));

    // State register plus the sweep counter, which restarts at slot 0
    // every time a sweep begins.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
        end
    end

    // Next-state logic: an accepted CLEAR starts the sweep, the sweep ends
    // after its last slot has been zeroed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_any && sel_op == OP_CLEAR) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shadow table: swept one slot per cycle during CLEAR, otherwise
    // written by the granted WRITE/DELETE when its index is in range.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) shadow_q[i] <= '0;
        end else if (state_q == ST_CLEAR) begin
            shadow_q[clr_cnt_q] <= '0;
        end else if (grant_any && idx_ok) begin
            if (sel_op == OP_WRITE)  shadow_q[sel_idx] <= sel_obj;
            if (sel_op == OP_DELETE) shadow_q[sel_idx] <= '0;
        end
    end

    // First-NONE finder: lowest slot whose shape is NONE, or MAX_LEN when
    // every slot holds a shape. Scanning downwards lets the lowest win.
    always_comb begin
        first_none = LEN_BITS'(MAX_LEN);
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (shadow_q[i][OBJ_WIDTH-1 -: ENUM_BITS] == SHAPE_NONE) begin
                first_none = LEN_BITS'(i);
            end
        end
    end

    // Live table and length only move on a commit edge; the commit pulse
    // is registered so it appears in the cycle after that edge.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) live_q[i] <= '0;
            len_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            commit_q <= commit_now;
            if (commit_now) begin
                for (int i = 0; i < MAX_LEN; i++) live_q[i] <= shadow_q[i];
                len_q <= first_none;
            end
        end
    end

    // dirty tracks shadow changes not yet committed. A dropped request
    // leaves the table alone, so it raises drop_err but not dirty.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            dirty_q    <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            if (commit_now) begin
                dirty_q <= 1'b0;
            end else if (grant_any && ((slot_op && idx_ok) || sel_op == OP_CLEAR)) begin
                dirty_q <= 1'b1;
            end
            if (grant_any && slot_op && !idx_ok) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign obj_arr_packed[g*OBJ_WIDTH +: OBJ_WIDTH] = live_q[g];
    end

    assign obj_arr_len = len_q;
    assign busy        = (state_q == ST_CLEAR);
    assign commit      = commit_q;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_obj_table_scheduler.sv
// tb_obj_table_scheduler
// Drives directed scenarios followed by random traffic into a 12-slot
// scheduler (so out-of-range indices exist) and compares every cycle
// against a table-level reference model of the scheduling rules.
module tb_obj_table_scheduler;
    import obj_pkg::*;

    localparam int OW = 66;
    localparam int ML = 12;
    localparam int IB = 4;
    localparam int LB = 6;
    localparam int TW = OW * ML;

    logic              clk25 = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [3:0]        req_op;
    logic [2*IB-1:0]   req_idx;
    logic [2*OW-1:0]   req_obj;
    logic [TW-1:0]     obj_arr_packed;
    logic [LB-1:0]     obj_arr_len;
    logic              busy;
    logic              commit;
    logic              drop_err;

    obj_table_scheduler #(
        .OBJ_WIDTH (OW),
        .MAX_LEN   (ML),
        .IDX_BITS  (IB),
        .LEN_BITS  (LB)
    ) dut (
        .clk25          (clk25),
        .rst            (rst),
        .frame_start    (frame_start),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_idx        (req_idx),
        .req_obj        (req_obj),
        .obj_arr_packed (obj_arr_packed),
        .obj_arr_len    (obj_arr_len),
        .busy           (busy),
        .commit         (commit),
        .drop_err       (drop_err)
    );

    always #20 clk25 = ~clk25;

    // Reference model state
    logic [OW-1:0] m_shadow [ML];
    logic [OW-1:0] m_live   [ML];
    int            m_len;
    bit            m_dirty;
    bit            m_ptr;
    bit            m_commit;
    bit            m_drop;
    int            m_clear_left;

    int checks   = 0;
    int failures = 0;
    int busy_cnt;

    task automatic checkOutput(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < ML; i++) begin
            m_shadow[i] = '0;
            m_live[i]   = '0;
        end
        m_len = 0; m_dirty = 0; m_ptr = 0; m_commit = 0; m_drop = 0; m_clear_left = 0;
    endfunction

    function automatic logic [1:0] modelGrant(input bit fs, input logic [1:0] valid);
        if (m_clear_left > 0) return 2'b00;
        if (fs && m_dirty)    return 2'b00;
        if (valid == 2'b11)   return m_ptr ? 2'b10 : 2'b01;
        return valid;
    endfunction

    function automatic logic [TW-1:0] modelPacked();
        logic [TW-1:0] p;
        for (int i = 0; i < ML; i++) p[i*OW +: OW] = m_live[i];
        return p;
    endfunction

    // Everything one clock edge does to the table, from pre-edge values.
    function automatic void modelEdge(input bit fs, input logic [1:0] valid, input logic [3:0] op,
                                      input logic [IB-1:0] idx0, input logic [IB-1:0] idx1,
                                      input logic [OW-1:0] obj0, input logic [OW-1:0] obj1);
        logic [1:0]    g;
        bit            do_commit;
        logic [1:0]    o;
        int            idx;
        logic [OW-1:0] obj;
        g = modelGrant(fs, valid);
        do_commit = (m_clear_left == 0) && fs && m_dirty;
        if (do_commit) begin
            m_len = ML;
            for (int i = ML - 1; i >= 0; i--) begin
                m_live[i] = m_shadow[i];
                if (m_shadow[i][OW-1 -: 4] == 4'd0) m_len = i;
            end
            m_dirty = 0;
        end
        if (m_clear_left > 0) begin
            m_shadow[ML - m_clear_left] = '0;
            m_clear_left--;
        end else if (g != 2'b00) begin
            o   = g[1] ? op[3:2] : op[1:0];
            idx = g[1] ? int'(idx1) : int'(idx0);
            obj = g[1] ? obj1 : obj0;
            m_ptr = g[0];
            if (o == 2'd1 || o == 2'd3) begin
                if (idx < ML) begin
                    m_shadow[idx] = (o == 2'd1) ? obj : '0;
                    m_dirty = 1;
                end else begin
                    m_drop = 1;
                end
            end else if (o == 2'd2) begin
                m_clear_left = ML;
                m_dirty = 1;
            end
        end
        m_commit = do_commit;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "_live"},   obj_arr_packed, modelPacked());
        checkOutput({tag, "_len"},    TW'(obj_arr_len), TW'(m_len));
        checkOutput({tag, "_commit"}, TW'(commit), TW'(m_commit));
        checkOutput({tag, "_busy"},   TW'(busy), TW'(m_clear_left > 0));
        checkOutput({tag, "_drop"},   TW'(drop_err), TW'(m_drop));
    endtask

    // One clock cycle: drive on the falling edge, check ready before the
    // rising edge, advance the model on it, check outputs just after.
    task automatic applyStimulus(input bit fs, input logic [1:0] valid, input logic [3:0] op,
                                 input logic [IB-1:0] idx0, input logic [IB-1:0] idx1,
                                 input logic [OW-1:0] obj0, input logic [OW-1:0] obj1);
        @(negedge clk25);
        frame_start = fs;
        req_valid   = valid;
        req_op      = op;
        req_idx     = {idx1, idx0};
        req_obj     = {obj1, obj0};
        #1;
        checkOutput("req_ready", TW'(req_ready), TW'(modelGrant(fs, valid)));
        @(posedge clk25);
        modelEdge(fs, valid, op, idx0, idx1, obj0, obj1);
        #1;
        checkAll("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 2'b00, 4'h0, '0, '0, '0, '0);
    endtask

    function automatic logic [OW-1:0] randObj();
        logic [63:0] r64;
        logic [3:0]  shape;
        r64   = {$urandom(), $urandom()};
        shape = 4'($urandom_range(0, 3));
        return {shape, r64[61:0]};
    endfunction

    function automatic logic [1:0] randOp();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return OP_CLEAR;
        if (r < 6)  return OP_NOP;
        if (r < 15) return OP_WRITE;
        return OP_DELETE;
    endfunction

    logic [OW-1:0] obj_c;
    logic [OW-1:0] obj_r;

    initial begin
        rst = 1'b0; frame_start = 1'b0; req_valid = 2'b00;
        req_op = '0; req_idx = '0; req_obj = '0;
        modelReset();
        obj_c = make_obj(SHAPE_CIRCLE, 10'd200, 10'd200, 10'd0, 10'd0, 10'd50, COLOR_RED);
        obj_r = make_obj(SHAPE_RECTANGLE, 10'd10, 10'd20, 10'd30, 10'd40, 10'd0, COLOR_GREEN);
        #50;
        checkAll("reset");
        @(negedge clk25);
        rst = 1'b1;

        // Both requesters valid two cycles in a row: 01 then 10
        applyStimulus(0, 2'b11, {OP_NOP, OP_NOP}, '0, '0, '0, '0);
        applyStimulus(0, 2'b11, {OP_NOP, OP_NOP}, '0, '0, '0, '0);

        // Write then commit
        applyStimulus(0, 2'b01, {OP_NOP, OP_WRITE}, 4'd2, '0, obj_c, '0);
        idle(2);
        checkOutput("t1_pre_slot2", TW'(obj_arr_packed[2*OW +: OW]), '0);
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);
        checkOutput("t1_slot2", TW'(obj_arr_packed[2*OW +: OW]), TW'(obj_c));
        checkOutput("t1_len", TW'(obj_arr_len), TW'(0));
        checkOutput("t1_commit", TW'(commit), TW'(1));
        idle(1);

        // frame_start without dirty: nothing happens
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);
        checkOutput("nodirty_commit", TW'(commit), TW'(0));

        // Same-cycle conflict: commit wins, write follows next cycle
        applyStimulus(0, 2'b10, {OP_WRITE, OP_NOP}, '0, 4'd0, '0, obj_r);
        applyStimulus(1, 2'b01, {OP_NOP, OP_WRITE}, 4'd1, '0, obj_r, '0);
        checkOutput("conf_commit", TW'(commit), TW'(1));
        applyStimulus(0, 2'b01, {OP_NOP, OP_WRITE}, 4'd1, '0, obj_r, '0);
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);

        // Full table: length saturates at MAX_LEN
        for (int i = 0; i < ML; i++)
            applyStimulus(0, 2'b01, {OP_NOP, OP_WRITE}, 4'(i), '0, obj_r, '0);
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);
        checkOutput("full_len", TW'(obj_arr_len), TW'(ML));

        // CLEAR with a frame_start in the middle of the sweep
        applyStimulus(0, 2'b01, {OP_NOP, OP_DELETE}, 4'd4, '0, '0, '0);
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);
        checkOutput("pre_clear_len", TW'(obj_arr_len), TW'(4));
        applyStimulus(0, 2'b10, {OP_CLEAR, OP_NOP}, '0, '0, '0, '0);
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= ML; c++) begin
            applyStimulus(c == 5, 2'b11, {OP_WRITE, OP_WRITE}, 4'd0, 4'd1, obj_c, obj_c);
            if (busy) busy_cnt++;
        end
        checkOutput("clear_busy_cycles", TW'(busy_cnt), TW'(ML));
        checkOutput("clear_no_commit_len", TW'(obj_arr_len), TW'(4));
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);
        checkOutput("clear_live", obj_arr_packed, '0);
        checkOutput("clear_len", TW'(obj_arr_len), TW'(0));

        // Reset in the middle of a sweep
        applyStimulus(0, 2'b01, {OP_NOP, OP_WRITE}, 4'd0, '0, obj_r, '0);
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);
        applyStimulus(0, 2'b01, {OP_NOP, OP_CLEAR}, '0, '0, '0, '0);
        idle(6);
        @(negedge clk25);
        rst = 1'b0;
        #1;
        modelReset();
        checkAll("midclr_rst");
        @(negedge clk25);
        rst = 1'b1;
        applyStimulus(0, 2'b10, 4'h0, '0, '0, '0, '0);
        applyStimulus(0, 2'b11, 4'h0, '0, '0, '0, '0);

        // Out-of-range index: accepted, table untouched, sticky error
        applyStimulus(0, 2'b01, {OP_NOP, OP_WRITE}, 4'd3, '0, obj_c, '0);
        applyStimulus(0, 2'b10, {OP_WRITE, OP_NOP}, '0, 4'd13, '0, obj_r);
        checkOutput("oor_drop", TW'(drop_err), TW'(1));
        applyStimulus(1, 2'b00, 4'h0, '0, '0, '0, '0);
        idle(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                          {randOp(), randOp()},
                          4'($urandom_range(0, ML - 1)), 4'($urandom_range(0, ML - 1)),
                          randObj(), randObj());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
